// File: rtl/riscv_core_dcache_axi_write_master.sv
// Single-beat AXI4 write master for the data-cache write-through path.
// Takes one store at a time, issues it on AW/W, waits for B and
// returns a one-cycle done pulse with an error flag.
module riscv_core_dcache_axi_write_master #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned CORE_DATA_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH  = 64,
    parameter int unsigned AXI_ID_WIDTH    = 4,
    parameter int unsigned AXI_ID          = 0
) (
    input  logic                        i_clk,
    input  logic                        i_rst,

    input  logic                        i_mem_write_valid,
    input  logic [ADDR_WIDTH-1:0]       i_mem_write_address,
    input  logic [CORE_DATA_WIDTH-1:0]  i_mem_write_data,
    input  logic [1:0]                  i_mem_write_size,
    output logic                        o_mem_write_done,
    output logic                        o_mem_write_err,

    output logic [AXI_ID_WIDTH-1:0]     o_awid,
    output logic [ADDR_WIDTH-1:0]       o_awaddr,
    output logic [7:0]                  o_awlen,
    output logic [2:0]                  o_awsize,
    output logic [1:0]                  o_awburst,
    output logic                        o_awvalid,
    input  logic                        i_awready,

    output logic [AXI_DATA_WIDTH-1:0]   o_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] o_wstrb,
    output logic                        o_wlast,
    output logic                        o_wvalid,
    input  logic                        i_wready,

    input  logic [AXI_ID_WIDTH-1:0]     i_bid,
    input  logic [1:0]                  i_bresp,
    input  logic                        i_bvalid,
    output logic                        o_bready
);

    localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;
    localparam int unsigned OFF_WIDTH  = $clog2(STRB_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_RESP = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    logic                       awvalid_q, awvalid_d;
    logic                       wvalid_q,  wvalid_d;
    logic                       bready_q,  bready_d;
    logic                       done_q,    done_d;
    logic                       err_q,     err_d;
    logic                       aw_sent_q, aw_sent_d;
    logic                       w_sent_q,  w_sent_d;
    logic [ADDR_WIDTH-1:0]      addr_q,    addr_d;
    logic [1:0]                 size_q,    size_d;
    logic [AXI_DATA_WIDTH-1:0]  wdata_q,   wdata_d;
    logic [STRB_WIDTH-1:0]      wstrb_q,   wstrb_d;

    logic [OFF_WIDTH-1:0]       req_off;
    logic [7:0]                 base_strb;
    logic [AXI_DATA_WIDTH-1:0]  req_wdata;
    logic [STRB_WIDTH-1:0]      req_wstrb;

    logic                       aw_hs;
    logic                       w_hs;
    logic                       b_hs;
    logic                       aw_done;
    logic                       w_done;

    // BID carries no information for a single-ID, single-outstanding master
    logic                       unused_bid;
    assign unused_bid = ^i_bid;

    // Handshake terms; a channel counts as sent if it completed earlier or completes now
    assign aw_hs   = awvalid_q & i_awready;
    assign w_hs    = wvalid_q & i_wready;
    assign b_hs    = bready_q & i_bvalid;
    assign aw_done = aw_sent_q | aw_hs;
    assign w_done  = w_sent_q | w_hs;

    // Place the store on its byte lanes within the AXI data bus
    always_comb begin
        req_off = i_mem_write_address[OFF_WIDTH-1:0];
        case (i_mem_write_size)
            2'b00:   base_strb = 8'h01;
            2'b01:   base_strb = 8'h03;
            2'b10:   base_strb = 8'h0F;
            default: base_strb = 8'hFF;
        endcase
        req_wdata = AXI_DATA_WIDTH'(i_mem_write_data) << {req_off, 3'b000};
        req_wstrb = STRB_WIDTH'(base_strb) << req_off;
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_mem_write_valid) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (aw_done && w_done) begin
                    state_d = ST_WAIT_RESP;
                end
            end
            ST_WAIT_RESP: begin
                if (b_hs) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Request is still held high this cycle; never reissue it
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs and capture registers
    always_comb begin
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        aw_sent_d = aw_sent_q;
        w_sent_d  = w_sent_q;
        addr_d    = addr_q;
        size_d    = size_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;

        case (state_q)
            ST_IDLE: begin
                if (i_mem_write_valid) begin
                    addr_d    = i_mem_write_address;
                    size_d    = i_mem_write_size;
                    wdata_d   = req_wdata;
                    wstrb_d   = req_wstrb;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    aw_sent_d = 1'b0;
                    w_sent_d  = 1'b0;
                end
            end
            ST_SEND: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_sent_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_sent_d = 1'b1;
                end
                if (aw_done && w_done) begin
                    bready_d = 1'b1;
                end
            end
            ST_WAIT_RESP: begin
                if (b_hs) begin
                    bready_d = 1'b0;
                    done_d   = 1'b1;
                    err_d    = (i_bresp != 2'b00);
                end
            end
            ST_DONE: begin
                done_d = 1'b0;
                err_d  = 1'b0;
            end
            default: begin
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                bready_d  = 1'b0;
            end
        endcase
    end

    // Output and capture registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            aw_sent_q <= 1'b0;
            w_sent_q  <= 1'b0;
            addr_q    <= '0;
            size_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            done_q    <= done_d;
            err_q     <= err_d;
            aw_sent_q <= aw_sent_d;
            w_sent_q  <= w_sent_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
        end
    end

    assign o_mem_write_done = done_q;
    assign o_mem_write_err  = err_q;

    assign o_awid    = AXI_ID_WIDTH'(AXI_ID);
    assign o_awaddr  = addr_q;
    assign o_awlen   = 8'd0;
    assign o_awsize  = {1'b0, size_q};
    assign o_awburst = 2'b01;
    assign o_awvalid = awvalid_q;

    assign o_wdata   = wdata_q;
    assign o_wstrb   = wstrb_q;
    assign o_wlast   = 1'b1;
    assign o_wvalid  = wvalid_q;

    assign o_bready  = bready_q;

endmodule

// File: tb/tb_riscv_core_dcache_axi_write_master.sv
// Bench for the dcache AXI write master: directed cases from the test plan,
// then randomized stores with random AW/W/B timing, all checked every cycle
// against a transaction-level model.
module tb_riscv_core_dcache_axi_write_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic        done;
    logic        err;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    initial forever #5 clk = ~clk;

    riscv_core_dcache_axi_write_master dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_mem_write_valid   (valid),
        .i_mem_write_address (addr),
        .i_mem_write_data    (data),
        .i_mem_write_size    (size),
        .o_mem_write_done    (done),
        .o_mem_write_err     (err),
        .o_awid              (awid),
        .o_awaddr            (awaddr),
        .o_awlen             (awlen),
        .o_awsize            (awsize),
        .o_awburst           (awburst),
        .o_awvalid           (awvalid),
        .i_awready           (awready),
        .o_wdata             (wdata),
        .o_wstrb             (wstrb),
        .o_wlast             (wlast),
        .o_wvalid            (wvalid),
        .i_wready            (wready),
        .i_bid               (bid),
        .i_bresp             (bresp),
        .i_bvalid            (bvalid),
        .o_bready            (bready)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Byte-lane placement: data byte j lands on lane off+j, strobe covers 2**size bytes
    function automatic void fmt(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                                output logic [63:0] wd, output logic [7:0] st);
        int off;
        int nb;
        off = int'(a[2:0]);
        nb  = 1 << s;
        wd  = '0;
        st  = '0;
        for (int j = 0; j < 4; j++)
            if (off + j < 8) wd[8*(off+j) +: 8] = d[8*j +: 8];
        for (int j = 0; j < nb; j++)
            if (off + j < 8) st[off+j] = 1'b1;
    endfunction

    // ---------------- transaction-level model ----------------
    bit          cmp_en = 0;
    bit          m_busy = 0;   // a request is owned from acceptance until its done cycle ends
    bit          m_awv = 0, m_wv = 0, m_bready = 0, m_done = 0, m_err = 0;
    logic [31:0] m_addr = '0;
    logic [1:0]  m_size = '0;
    logic [63:0] m_wdata = '0;
    logic [7:0]  m_strb = '0;
    bit          p_aw_hs, p_w_hs, p_b_hs, p_sent, p_accept;
    int          dut_aw = 0, dut_w = 0, dut_done = 0;

    always @(posedge clk) begin
        dut_aw   += int'(awvalid && awready);
        dut_w    += int'(wvalid && wready);
        dut_done += int'(done);
        if (rst) begin
            m_busy = 0; m_awv = 0; m_wv = 0; m_bready = 0; m_done = 0; m_err = 0;
        end else begin
            p_aw_hs  = m_awv && awready;
            p_w_hs   = m_wv && wready;
            p_b_hs   = m_bready && bvalid;
            p_sent   = (m_awv || m_wv) && (!m_awv || p_aw_hs) && (!m_wv || p_w_hs);
            p_accept = !m_busy && valid;
            if (m_done) m_busy = 0;
            m_done = p_b_hs;
            m_err  = p_b_hs && (bresp != 2'b00);
            if (p_aw_hs) m_awv = 0;
            if (p_w_hs)  m_wv  = 0;
            if (p_b_hs) m_bready = 0;
            else if (p_sent) m_bready = 1;
            if (p_accept) begin
                m_busy = 1; m_awv = 1; m_wv = 1;
                m_addr = addr; m_size = size;
                fmt(addr, data, size, m_wdata, m_strb);
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("awvalid", awvalid, m_awv);
            chk("wvalid", wvalid, m_wv);
            chk("bready", bready, m_bready);
            chk("done", done, m_done);
            if (m_done) chk("err", err, m_err);
            if (m_awv) begin
                chk("awaddr", awaddr, m_addr);
                chk("awsize", awsize, {1'b0, m_size});
                chk("awid", awid, 0);
                chk("awlen", awlen, 0);
                chk("awburst", awburst, 2'b01);
            end
            if (m_wv) begin
                chk("wdata", wdata, m_wdata);
                chk("wstrb", wstrb, m_strb);
                chk("wlast", wlast, 1);
            end
        end
    end

    // ---------------- stimulus ----------------
    int issued = 0;
    int exp_done = 0;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic rand_slave();
        awready = ($urandom_range(0, 99) < 60);
        wready  = ($urandom_range(0, 99) < 60);
        bvalid  = ($urandom_range(0, 99) < 50);
        bresp   = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        bid     = 4'($urandom);
    endtask

    task automatic start_req(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        valid = 1'b1; addr = a; data = d; size = s;
        issued++;
    endtask

    task automatic wait_done(input bit rnd, output int lat);
        lat = 0;
        do begin
            if (rnd) rand_slave();
            step();
            lat++;
        end while (!done && lat < 200);
        chk("done_seen", done, 1);
        exp_done++;
    endtask

    // Controller keeps valid through the done cycle, then releases it
    task automatic end_req();
        step();
        valid = 1'b0;
    endtask

    logic [63:0] f_wd;
    logic [7:0]  f_st;
    int          lat;
    int          aw0, w0, d0;

    initial begin
        rst = 1'b1; valid = 1'b0; addr = '0; data = '0; size = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; bid = '0;
        step(); step();
        cmp_en = 1;
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_bready", bready, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;

        // Pin the formatting model with hand-computed values
        fmt(32'h0000_1004, 32'hDEADBEEF, 2'b10, f_wd, f_st);
        chk("fmt_word_wdata", f_wd, 64'hDEADBEEF_00000000);
        chk("fmt_word_wstrb", f_st, 8'hF0);
        fmt(32'h0000_1005, 32'h0000_00AB, 2'b00, f_wd, f_st);
        chk("fmt_byte_wdata", f_wd, 64'h0000AB00_00000000);
        chk("fmt_byte_wstrb", f_st, 8'h20);

        // Word store, minimum latency
        awready = 1; wready = 1; bvalid = 0; bresp = 2'b00;
        start_req(32'h0000_1004, 32'hDEADBEEF, 2'b10);
        step();
        chk("t1_awvalid", awvalid, 1);
        chk("t1_awaddr", awaddr, 32'h1004);
        chk("t1_awsize", awsize, 3'b010);
        chk("t1_wdata", wdata, 64'hDEADBEEF_00000000);
        chk("t1_wstrb", wstrb, 8'hF0);
        chk("t1_wlast", wlast, 1);
        step();
        chk("t2_bready", bready, 1);
        chk("t2_done", done, 0);
        bvalid = 1;
        step();
        chk("t3_done", done, 1);
        chk("t3_err", err, 0);
        exp_done++;
        bvalid = 0;
        step();
        chk("t4_done", done, 0);
        chk("t4_no_reissue", awvalid, 0);
        valid = 0;

        // Byte store
        step();
        bvalid = 1;
        start_req(32'h0000_1005, 32'h0000_00AB, 2'b00);
        step();
        chk("byte_wdata", wdata, 64'h0000AB00_00000000);
        chk("byte_wstrb", wstrb, 8'h20);
        wait_done(0, lat);
        chk("byte_latency", lat, 2);
        end_req();

        // AW accepted late, W accepted immediately
        awready = 0; wready = 1; bvalid = 1;
        start_req(32'h0000_2000, 32'h1234_5678, 2'b10);
        step();
        chk("bp_t1_awvalid", awvalid, 1);
        chk("bp_t1_wvalid", wvalid, 1);
        step();
        chk("bp_t2_wvalid", wvalid, 0);
        chk("bp_t2_awvalid", awvalid, 1);
        chk("bp_t2_bready", bready, 0);
        step(); step();
        chk("bp_t4_awaddr", awaddr, 32'h2000);
        chk("bp_t4_bready", bready, 0);
        step();
        awready = 1;
        step();
        chk("bp_t6_awvalid", awvalid, 0);
        chk("bp_t6_bready", bready, 1);
        step();
        chk("bp_t7_done", done, 1);
        exp_done++;
        end_req();

        // SLVERR then OKAY
        awready = 1; wready = 1; bvalid = 1; bresp = 2'b10;
        start_req(32'h0000_3003, 32'hCAFE_F00D, 2'b00);
        wait_done(0, lat);
        chk("slverr_err", err, 1);
        end_req();
        bresp = 2'b00;
        start_req(32'h0000_3008, 32'h0BAD_BEEF, 2'b11);
        wait_done(0, lat);
        chk("okay_err", err, 0);
        end_req();

        // Back-to-back: valid re-asserted the cycle after done
        aw0 = dut_aw; w0 = dut_w; d0 = dut_done;
        start_req(32'h0000_4002, 32'h0000_BEEF, 2'b01);
        wait_done(0, lat);
        step();
        start_req(32'h0000_4006, 32'h0000_1234, 2'b01);
        wait_done(0, lat);
        end_req();
        step();
        chk("b2b_aw_count", dut_aw - aw0, 2);
        chk("b2b_w_count", dut_w - w0, 2);
        chk("b2b_done_count", dut_done - d0, 2);

        // Reset while waiting for B
        bvalid = 0;
        start_req(32'h0000_5000, 32'h5555_AAAA, 2'b10);
        step(); step();
        chk("rstw_bready_before", bready, 1);
        rst = 1; valid = 0;
        step();
        chk("rstw_awvalid", awvalid, 0);
        chk("rstw_wvalid", wvalid, 0);
        chk("rstw_bready", bready, 0);
        chk("rstw_done", done, 0);
        rst = 0; bvalid = 1;
        repeat (3) begin
            step();
            chk("rstw_no_done", done, 0);
        end

        // Randomized stores with random channel timing
        for (int n = 0; n < 80; n++) begin
            start_req($urandom, $urandom, 2'($urandom_range(0, 3)));
            wait_done(1, lat);
            if ($urandom_range(0, 1) == 0) begin
                step();
            end else begin
                end_req();
                repeat ($urandom_range(0, 2)) begin
                    rand_slave();
                    step();
                end
            end
        end
        valid = 0;
        bvalid = 0;
        repeat (3) step();

        chk("total_aw", dut_aw, issued);
        chk("total_w", dut_w, issued);
        chk("total_done", dut_done, exp_done);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/riscv_core_dcache_axi_write_master.md
Name: riscv_core_dcache_axi_write_master

Overview:
AXI4 write-channel master that sits directly downstream of the data-cache controller's write-through path. It accepts one store request at a time (address, data, size) over a level-valid/done handshake and issues it as a single-beat AXI4 write on AW/W. It then waits for the B response and returns a one-cycle done pulse (plus an error flag) to the cache controller. There is no buffering beyond one request; the controller stalls the core until done.

Parameters:
ADDR_WIDTH, 32, request and AWADDR width
CORE_DATA_WIDTH, 32, store data width from core
AXI_DATA_WIDTH, 64, AXI W data width; strobe width is AXI_DATA_WIDTH/8
AXI_ID_WIDTH, 4, AWID/BID width
AXI_ID, 0, constant AWID value

Ports:
i_clk  in  1  clock; all logic on rising edge
i_rst  in  1  synchronous, active-high reset
i_mem_write_valid  in  1  store request; held high by the controller until o_mem_write_done
i_mem_write_address  in  ADDR_WIDTH  byte address of the store
i_mem_write_data  in  CORE_DATA_WIDTH  store data, LSB-aligned
i_mem_write_size  in  2  00 byte, 01 half, 10 word, 11 dword
o_mem_write_done  out  1  one-cycle pulse: B response received
o_mem_write_err  out  1  valid with done; 1 if BRESP != OKAY
o_awid  out  AXI_ID_WIDTH  = AXI_ID
o_awaddr  out  ADDR_WIDTH  captured address
o_awlen  out  8  constant 0
o_awsize  out  3  {1'b0, captured size}
o_awburst  out  2  constant 01 (INCR)
o_awvalid  out  1  AW valid
i_awready  in  1  AW ready
o_wdata  out  AXI_DATA_WIDTH  lane-shifted data
o_wstrb  out  AXI_DATA_WIDTH/8  lane-shifted strobe
o_wlast  out  1  constant 1 whenever o_wvalid
o_wvalid  out  1  W valid
i_wready  in  1  W ready
i_bid  in  AXI_ID_WIDTH  ignored beyond capture
i_bresp  in  2  write response
i_bvalid  in  1  B valid
o_bready  out  1  B ready

Behaviour:
- Reset (i_rst=1 at an edge): state IDLE. o_awvalid, o_wvalid, o_bready, o_mem_write_done and o_mem_write_err become 0. Capture registers are cleared. Reset mid-transaction abandons it, with no done pulse.
- FSM states: IDLE, SEND, WAIT_RESP, DONE.
- IDLE: if i_mem_write_valid, capture address, size and formatted data/strobe, set o_awvalid=o_wvalid=1, clear aw_sent/w_sent flags, go to SEND.
- Data formatting: o_wdata = zero-extended data << (8*addr[2:0]), truncated to AXI_DATA_WIDTH. Base strobe is size 00→0x01, 01→0x03, 10→0x0F, 11→0xFF. o_wstrb = base << addr[2:0], truncated to 8 bits. No alignment check; the controller already faults misaligned accesses.
- SEND: AW and W are independent.
  - AW handshake (o_awvalid & i_awready) drops o_awvalid next cycle and sets aw_sent.
  - W handshake likewise drops o_wvalid and sets w_sent.
  - Both may complete in the same cycle, in either order, or on different cycles.
  - When both are sent (including completions this cycle), go to WAIT_RESP with o_bready=1.
  - AW/W payload stays stable while the corresponding valid is high.
  - Once asserted, valid is never withdrawn before its handshake, even if i_mem_write_valid drops.
- WAIT_RESP: o_bready=1. On i_bvalid, latch err = (i_bresp != 2'b00), drop o_bready, go to DONE.
- DONE: o_mem_write_done=1 and o_mem_write_err=latched err for exactly one cycle. i_mem_write_valid is ignored this cycle, so the same request is never reissued. Next state is IDLE.
- Latency: minimum 3 cycles from valid to done (valid at T0; AW/W handshakes at T1; B at T2; done at T3). Backpressure cycles add 1:1.
- Back-to-back: a new valid seen in IDLE the cycle after DONE starts a new transaction immediately.
- At most one outstanding AXI write; no write data interleaving.

Test Plan:
- Word store addr=0x0000_1004, data=0xDEADBEEF, size=10, ready always high -> at T1 awaddr=0x1004, awsize=010, wdata=0xDEADBEEF_00000000, wstrb=0xF0, wlast=1; bvalid at T2 with OKAY -> done=1, err=0 at T3 only.
- Byte store addr=0x1005, data=0x000000AB, size=00 -> wdata=0x0000AB00_00000000, wstrb=0x20.
- AW ready delayed 4 cycles, W accepted at T1 -> wvalid drops at T2, awvalid held with stable awaddr until accepted; bready asserts only after AW handshake; done 1 cycle after B.
- bresp=10 (SLVERR) -> done=1 with err=1 for one cycle; next request with OKAY gives err=0.
- Two consecutive requests with valid re-asserted the cycle after done -> exactly two AW and two W handshakes, two done pulses, no duplicate issue.
- i_rst=1 while in WAIT_RESP -> next cycle all valids, bready and done are 0 and state is IDLE; no done pulse for the aborted store.
